// File: rtl/stereo_mpx_encoder.sv
// rtl/stereo_mpx_encoder.sv - stereo FM multiplex encoder with shared multiplier and pilot phase accumulator
module stereo_mpx_encoder #(
    parameter int DW        = 18,
    parameter int PHASE_W   = 24,
    parameter int PILOT_INC = 1660245,
    parameter int LUT_AW    = 10,
    parameter int PILOT_AMP = 13107
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sample_valid,
    input  logic [DW-1:0] left,
    input  logic [DW-1:0] right,
    input  logic          mono_mode,
    input  logic          pilot_en,
    input  logic          resync,
    output logic [DW:0]   mpx,
    output logic          mpx_valid,
    output logic          overrun
);
    localparam int LUT_N = 1 << LUT_AW;

    typedef enum logic [2:0] {
        S_IDLE, S_SUMDIFF, S_LUT, S_MUL_S, S_MUL_P, S_OUT
    } state_t;

    state_t state, state_nx;

    logic ld_in, ld_sd, ld_lut, ld_sub, ld_pil, ld_out;

    logic [DW-1:0]      l_q, r_q, m_q, s_q, sinp_q, sins_q, sub_q, pil_q;
    logic               mono_q, pen_q;
    logic [PHASE_W-1:0] phase;
    logic [DW:0]        sum_lr, dif_lr;
    logic [DW-1:0]      mul_a, mul_b, prod_sh;
    logic [2*DW-1:0]    prod;
    logic [LUT_AW-1:0]  idx_p, idx_s;
    logic [DW-1:0]      sine_lut [LUT_N];
    logic               unused_bits;

    // Full-period sine table, rounded half away from zero, evaluated at elaboration
    function automatic logic [DW-1:0] sine_entry(input int k);
        real amp, v;
        amp = real'((2 ** (DW - 1)) - 1);
        v   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_N));
        v   = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return DW'($rtoi(v));
    endfunction

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign sine_lut[k] = sine_entry(k);
    end

    // Both halves are formed one bit wider, so halving can never overflow
    assign sum_lr = {l_q[DW-1], l_q} + {r_q[DW-1], r_q};
    assign dif_lr = {l_q[DW-1], l_q} - {r_q[DW-1], r_q};

    // Doubling the phase is just a one-bit shift of the table window; the carry out is the mod wrap
    assign idx_p = phase[PHASE_W-1 -: LUT_AW];
    assign idx_s = phase[PHASE_W-2 -: LUT_AW];

    // One multiplier: subcarrier product in MUL_S, pilot product in MUL_P.
    // Operands are sign-extended so the unsigned product equals the signed one modulo 2^(2*DW).
    assign mul_a   = ld_pil ? sinp_q : s_q;
    assign mul_b   = ld_pil ? DW'(PILOT_AMP) : sins_q;
    assign prod    = {{DW{mul_a[DW-1]}}, mul_a} * {{DW{mul_b[DW-1]}}, mul_b};
    assign prod_sh = prod[2*DW-2 -: DW];

    assign unused_bits = ^{sum_lr[0], dif_lr[0], prod[2*DW-1], prod[DW-2:0]};

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state: accept only from IDLE, then walk the fixed six-step sequence
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (sample_valid) state_nx = S_SUMDIFF;
            S_SUMDIFF: state_nx = S_LUT;
            S_LUT:     state_nx = S_MUL_S;
            S_MUL_S:   state_nx = S_MUL_P;
            S_MUL_P:   state_nx = S_OUT;
            S_OUT:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // State decode into per-step load enables
    always_comb begin
        ld_in  = 1'b0;
        ld_sd  = 1'b0;
        ld_lut = 1'b0;
        ld_sub = 1'b0;
        ld_pil = 1'b0;
        ld_out = 1'b0;
        case (state)
            S_IDLE:    ld_in  = sample_valid;
            S_SUMDIFF: ld_sd  = 1'b1;
            S_LUT:     ld_lut = 1'b1;
            S_MUL_S:   ld_sub = 1'b1;
            S_MUL_P:   ld_pil = 1'b1;
            S_OUT:     ld_out = 1'b1;
            default:   ;
        endcase
    end

    // Sample datapath; mode bits are latched with the sample so they cannot change mid-flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            l_q       <= '0;
            r_q       <= '0;
            mono_q    <= 1'b0;
            pen_q     <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
            sinp_q    <= '0;
            sins_q    <= '0;
            sub_q     <= '0;
            pil_q     <= '0;
            mpx       <= '0;
            mpx_valid <= 1'b0;
        end else begin
            if (ld_in) begin
                l_q    <= left;
                r_q    <= right;
                mono_q <= mono_mode;
                pen_q  <= pilot_en;
            end
            if (ld_sd) begin
                m_q <= sum_lr[DW:1];
                s_q <= mono_q ? '0 : dif_lr[DW:1];
            end
            if (ld_lut) begin
                sinp_q <= sine_lut[idx_p];
                sins_q <= sine_lut[idx_s];
            end
            if (ld_sub) sub_q <= prod_sh;
            if (ld_pil) pil_q <= (pen_q && !mono_q) ? prod_sh : '0;
            if (ld_out) mpx <= {m_q[DW-1], m_q} + {sub_q[DW-1], sub_q} + {pil_q[DW-1], pil_q};
            mpx_valid <= ld_out;
        end
    end

    // Pilot phase accumulator: resync wins over the once-per-sample advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      phase <= '0;
        else if (resync) phase <= '0;
        else if (ld_pil) phase <= phase + PHASE_W'(PILOT_INC);
    end

    // Sticky flag for strobes arriving while a sample is still in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                               overrun <= 1'b0;
        else if (sample_valid && state != S_IDLE) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_stereo_mpx_encoder.sv
// tb/tb_stereo_mpx_encoder.sv - scoreboard bench for stereo_mpx_encoder
module tb_stereo_mpx_encoder;
    localparam int DW = 18;

    typedef struct {
        int inst;
        int val;
        int due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sv   [3];
    logic [DW-1:0] lft  [3];
    logic [DW-1:0] rgt  [3];
    logic          mono [3];
    logic          pen  [3];
    logic          rsy  [3];
    logic [DW:0]   mpx  [3];
    logic          mv   [3];
    logic          ovr  [3];

    exp_t q[$];
    exp_t me;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int unsigned ph0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    stereo_mpx_encoder u0 (
        .clock(clock), .reset(reset), .sample_valid(sv[0]), .left(lft[0]), .right(rgt[0]),
        .mono_mode(mono[0]), .pilot_en(pen[0]), .resync(rsy[0]),
        .mpx(mpx[0]), .mpx_valid(mv[0]), .overrun(ovr[0]));

    stereo_mpx_encoder #(.PILOT_INC(2 ** 21)) u1 (
        .clock(clock), .reset(reset), .sample_valid(sv[1]), .left(lft[1]), .right(rgt[1]),
        .mono_mode(mono[1]), .pilot_en(pen[1]), .resync(rsy[1]),
        .mpx(mpx[1]), .mpx_valid(mv[1]), .overrun(ovr[1]));

    stereo_mpx_encoder #(.PILOT_INC(2 ** 22)) u2 (
        .clock(clock), .reset(reset), .sample_valid(sv[2]), .left(lft[2]), .right(rgt[2]),
        .mono_mode(mono[2]), .pilot_en(pen[2]), .resync(rsy[2]),
        .mpx(mpx[2]), .mpx_valid(mv[2]), .overrun(ovr[2]));

    // Monitor: every output pulse must match the oldest pending expectation, value and cycle
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (mv[i]) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse inst%0d got=%0d at cycle %0d exp=no pulse",
                             i, $signed(mpx[i]), cyc);
                end else begin
                    me = q.pop_front();
                    if (me.inst != i || me.val != int'($signed(mpx[i])) || me.due != cyc) begin
                        failures++;
                        $display("FAIL mpx inst%0d got=%0d cycle=%0d exp inst%0d val=%0d cycle=%0d",
                                 i, $signed(mpx[i]), cyc, me.inst, me.val, me.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One-cycle strobe; expectation queued only when the strobe should be accepted
    task automatic issue(input int i, input int l, input int r, input bit m, input bit p,
                         input bit acc, input int ev);
        exp_t e;
        @(posedge clock); #1;
        lft[i] = DW'(l);
        rgt[i] = DW'(r);
        mono[i] = m;
        pen[i] = p;
        sv[i] = 1'b1;
        if (acc) begin
            e.inst = i;
            e.val  = ev;
            e.due  = cyc + 6;
            q.push_back(e);
        end
        @(posedge clock); #1;
        sv[i] = 1'b0;
    endtask

    task automatic pulse_resync(input int i);
        @(posedge clock); #1;
        rsy[i] = 1'b1;
        @(posedge clock); #1;
        rsy[i] = 1'b0;
    endtask

    function automatic int lut(input int k);
        real v;
        v = 131071.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
        v = (v >= 0.0) ? v + 0.5 : v - 0.5;
        return $rtoi(v);
    endfunction

    // Reference for the default-parameter instance with pilot enabled, stereo mode
    function automatic int model(input int l, input int r, input int unsigned ph);
        int     m, s, sp, ss;
        longint sub, pil;
        m   = (l + r) >>> 1;
        s   = (l - r) >>> 1;
        sp  = lut(int'((ph >> 14) & 32'h3FF));
        ss  = lut(int'(((ph << 1) & 32'hFFFFFF) >> 14));
        sub = (longint'(s) * longint'(ss)) >>> 17;
        pil = (longint'(sp) * 64'sd13107) >>> 17;
        return m + int'(sub) + int'(pil);
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; lft[i] = '0; rgt[i] = '0;
            mono[i] = 1'b0; pen[i] = 1'b0; rsy[i] = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        chk("reset_mpx", int'($signed(mpx[0])), 0);
        chk("reset_valid", int'(mv[0]), 0);
        chk("reset_overrun", int'(ovr[0]), 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Mono: side and pilot both forced out
        issue(0, 1000, -1000, 1, 1, 1, 0);
        repeat (6) @(posedge clock);
        issue(0, 1000, 1000, 1, 1, 1, 1000);
        repeat (8) @(posedge clock);

        // Overrun: second strobe three cycles later is dropped
        issue(0, 500, 500, 1, 0, 1, 500);
        @(posedge clock);
        issue(0, -7, -7, 1, 0, 0, 0);
        repeat (10) @(posedge clock);
        #1 chk("overrun_set", int'(ovr[0]), 1);
        repeat (10) @(posedge clock);
        #1 chk("overrun_sticky", int'(ovr[0]), 1);

        // Reset in the middle of a sample discards it
        issue(0, 1234, 1234, 1, 1, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("midreset_mpx", int'($signed(mpx[0])), 0);
        chk("midreset_valid", int'(mv[0]), 0);
        chk("midreset_overrun", int'(ovr[0]), 0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (12) @(posedge clock);
        issue(0, 1000, -1000, 0, 1, 1, 0);
        repeat (8) @(posedge clock);

        // Subcarrier: eighth-turn pilot step, pilot disabled
        issue(1, 1000, -1000, 0, 0, 1, 0);
        repeat (6) @(posedge clock);
        issue(1, 1000, -1000, 0, 0, 1, 999);
        repeat (6) @(posedge clock);
        issue(1, 1000, -1000, 0, 0, 1, 0);
        repeat (6) @(posedge clock);
        issue(1, 1000, -1000, 0, 0, 1, -1000);
        repeat (8) @(posedge clock);

        // Pilot: quarter-turn step, silent audio, then resync back to phase 0
        issue(2, 0, 0, 0, 1, 1, 0);
        repeat (6) @(posedge clock);
        issue(2, 0, 0, 0, 1, 1, 13106);
        repeat (6) @(posedge clock);
        issue(2, 0, 0, 0, 1, 1, 0);
        repeat (8) @(posedge clock);
        pulse_resync(2);
        issue(2, 0, 0, 0, 1, 1, 0);
        repeat (6) @(posedge clock);
        issue(2, 0, 0, 0, 1, 1, 13106);
        repeat (8) @(posedge clock);

        // Throughput: back-to-back strobes at the minimum spacing
        pulse_resync(0);
        ph0 = 0;
        for (int n = 0; n < 100; n++) begin
            int l, r;
            l = int'($urandom_range(0, 262143)) - 131072;
            r = int'($urandom_range(0, 262143)) - 131072;
            issue(0, l, r, 0, 1, 1, model(l, r, ph0));
            ph0 = (ph0 + 32'd1660245) & 32'hFFFFFF;
            repeat (4) @(posedge clock);
        end
        repeat (20) @(posedge clock);
        #1 chk("throughput_overrun", int'(ovr[0]), 0);
        chk("pending_expectations", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
